fifo_wr_arbiter: RTL

Round-robin write arbiter that shares the single write port of a `fifo_sync` instance among `NREQ` requesters, each using a valid/ready handshake. It sits directly in front of the FIFO and drives its `wr_en_i`/`wr_data_i` from the granted requester. It consumes the FIFO's `full_o` for backpressure. An optional burst lock keeps one requester's multi-beat packet contiguous in the FIFO.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Round-robin successor; the wrap is explicit so non-power-of-two NREQ works.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority finder: first set bit of req at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int unsigned j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr) + k) % NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready requesters.
// Define FIFO_ARB_LOCK_EN to keep multi-beat packets (req_last_i) contiguous in the FIFO.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [NREQ-1:0]  req_valid_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    input  logic [NREQ-1:0]  req_last_i,
    output logic [NREQ-1:0]  req_ready_o,
    output logic             fifo_wr_en_o,
    output logic [DW-1:0]    fifo_wr_data_o,
    input  logic             fifo_full_i,
    output logic [NREQ-1:0]  grant_o,
    output logic             busy_o
);

    localparam int unsigned IW = $clog2(NREQ);

    arb_state_t      state_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   rr_ptr_q;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   gidx;
    logic            has_grant;
    logic            xfer;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req (req_valid_i),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Reset forces every output low, even though the state registers alone would show IDLE.
    always_comb begin
        grant     = '0;
        gidx      = '0;
        has_grant = 1'b0;
        if (reset_i) begin
            has_grant = 1'b0;
        end else if (state_q == BURST) begin
            grant[owner_q] = 1'b1;
            gidx           = owner_q;
            has_grant      = 1'b1;
        end else begin
            grant     = pick_gnt;
            gidx      = pick_idx;
            has_grant = pick_any;
        end
    end

    assign xfer           = has_grant & req_valid_i[gidx] & ~fifo_full_i;
    assign req_ready_o    = grant & {NREQ{~fifo_full_i}};
    assign grant_o        = grant;
    assign fifo_wr_en_o   = xfer;
    assign fifo_wr_data_o = has_grant ? req_data_i[32'(gidx)*DW +: DW] : '0;
    assign busy_o         = (state_q == BURST);

`ifdef FIFO_ARB_LOCK_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else if (xfer) begin
            unique case (state_q)
                IDLE: begin
                    if (req_last_i[gidx]) begin
                        rr_ptr_q <= IW'(rr_next(32'(gidx), NREQ));
                    end else begin
                        state_q <= BURST;
                        owner_q <= gidx;
                    end
                end
                BURST: begin
                    if (req_last_i[gidx]) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= IW'(rr_next(32'(owner_q), NREQ));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last_i;
    assign state_q     = IDLE;
    assign owner_q     = '0;

    // Without the lock every accepted beat re-arbitrates.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr_q <= '0;
        end else if (xfer) begin
            rr_ptr_q <= IW'(rr_next(32'(gidx), NREQ));
        end
    end
`endif

endmodule
